// File: rtl/var_delay_line_pkg.sv
// Shared helpers for the variable delay line.
package var_delay_line_pkg;

    localparam int unsigned DefaultWidth = 32;

    // Maps a requested delay onto the legal range 1..max_delay.
    function automatic int unsigned clamp_delay(input int unsigned req,
                                                input int unsigned max_delay);
        if (req == 0) begin
            return 1;
        end else if (req > max_delay) begin
            return max_delay;
        end
        return req;
    endfunction

endpackage

// File: rtl/dly_ring_ram.sv
// Ring storage for the delay line: synchronous write, asynchronous read at the same address.
module dly_ring_ram #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 8
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read returns the pre-write contents, so pop and push share one address per edge.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/var_delay_line.sv
// Runtime-configurable delay line: circular buffer of delay_q slots with per-slot valid bits,
// stall enable, flush and delay reconfiguration.
module var_delay_line
    import var_delay_line_pkg::*;
#(
    parameter int unsigned WIDTH         = DefaultWidth,
    parameter int unsigned MAX_DELAY     = 256,
    parameter int unsigned DEFAULT_DELAY = 8,
    localparam int unsigned DW           = $clog2(MAX_DELAY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             cfg_we,
    input  logic [DW-1:0]    cfg_delay,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [DW-1:0]    delay_q,
    output logic [DW-1:0]    occ
);

    localparam int unsigned AW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
    } slot_t;

    logic [MAX_DELAY-1:0] valid_q, valid_d;
    logic [DW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]        occ_q, occ_d;
    logic [DW-1:0]        delay_d;
    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;

    logic [AW-1:0]        addr;
    logic [WIDTH-1:0]     ram_rdata;
    logic                 ram_we;
    slot_t                pop;

    assign addr      = wr_ptr_q[AW-1:0];
    assign pop.valid = valid_q[addr];
    assign pop.data  = ram_rdata;

    dly_ring_ram #(
        .WIDTH (WIDTH),
        .DEPTH (MAX_DELAY),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (addr),
        .wdata_i (in_data),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        valid_d     = valid_q;
        wr_ptr_d    = wr_ptr_q;
        occ_d       = occ_q;
        delay_d     = delay_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ram_we      = 1'b0;

        if (cfg_we || flush) begin
            // cfg_we carries the full flush action; out_data deliberately holds.
            if (cfg_we) begin
                delay_d = DW'(clamp_delay(32'(cfg_delay), MAX_DELAY));
            end
            valid_d     = '0;
            wr_ptr_d    = '0;
            occ_d       = '0;
            out_valid_d = 1'b0;
        end else if (en) begin
            ram_we        = 1'b1;
            valid_d[addr] = in_valid;
            out_valid_d   = pop.valid;
            if (pop.valid) begin
                out_data_d = pop.data;
            end
            wr_ptr_d = (wr_ptr_q == delay_q - 1'b1) ? '0 : wr_ptr_q + 1'b1;
            occ_d    = occ_q + DW'(in_valid) - DW'(pop.valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            delay_q     <= DW'(DEFAULT_DELAY);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            delay_q     <= delay_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign occ       = occ_q;

endmodule

// File: tb/tb_var_delay_line.sv
// Self-checking bench for var_delay_line: FIFO-style reference model feeds a per-edge scoreboard.
module tb_var_delay_line;

    localparam int unsigned WIDTH         = 32;
    localparam int unsigned MAX_DELAY     = 256;
    localparam int unsigned DEFAULT_DELAY = 8;
    localparam int unsigned DW            = $clog2(MAX_DELAY + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             cfg_we = 1'b0;
    logic [DW-1:0]    cfg_delay = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [DW-1:0]    delay_q;
    logic [DW-1:0]    occ;

    var_delay_line #(
        .WIDTH         (WIDTH),
        .MAX_DELAY     (MAX_DELAY),
        .DEFAULT_DELAY (DEFAULT_DELAY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .cfg_we    (cfg_we),
        .cfg_delay (cfg_delay),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .delay_q   (delay_q),
        .occ       (occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit               v;
        logic [WIDTH-1:0] d;
    } word_t;

    typedef struct {
        logic             ov;
        logic [WIDTH-1:0] od;
        int unsigned      occ;
        int unsigned      dly;
    } exp_t;

    // Reference: words in flight since the last flush, oldest first.
    word_t            hist[$];
    int unsigned      m_delay = DEFAULT_DELAY;
    logic             m_ov = 1'b0;
    logic [WIDTH-1:0] m_od = '0;
    exp_t             exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int unsigned model_clamp(input int unsigned req);
        if (req < 1) return 1;
        if (req > MAX_DELAY) return MAX_DELAY;
        return req;
    endfunction

    // One clock edge of stimulus plus the model's prediction of what follows it.
    task automatic step(input bit r, input bit e, input bit f, input bit c, input int unsigned cd,
                        input bit iv, input logic [WIDTH-1:0] id);
        word_t p;
        exp_t  x;
        int unsigned cnt;
        @(negedge clk);
        rst       = r;
        en        = e;
        flush     = f;
        cfg_we    = c;
        cfg_delay = DW'(cd);
        in_valid  = iv;
        in_data   = id;
        if (r) begin
            m_delay = DEFAULT_DELAY;
            hist.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else if (c || f) begin
            if (c) m_delay = model_clamp(int'(cfg_delay));
            hist.delete();
            m_ov = 1'b0;
        end else if (e) begin
            p.v = 1'b0;
            p.d = '0;
            if (hist.size() == m_delay) p = hist.pop_front();
            m_ov = p.v;
            if (p.v) m_od = p.d;
            p.v = iv;
            p.d = id;
            hist.push_back(p);
        end
        cnt = 0;
        foreach (hist[i]) if (hist[i].v) cnt++;
        x.ov  = m_ov;
        x.od  = m_od;
        x.occ = cnt;
        x.dly = m_delay;
        exp_q.push_back(x);
    endtask

    task automatic shift(input bit iv, input logic [WIDTH-1:0] id);
        step(1'b0, 1'b1, 1'b0, 1'b0, 0, iv, id);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) shift(1'b0, $urandom);
    endtask

    task automatic cfg(input int unsigned d);
        step(1'b0, 1'b1, 1'b0, 1'b1, d, 1'b0, '0);
    endtask

    // Monitor: every edge presents a new output state; compare it against the next prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("out_valid", WIDTH'(out_valid), WIDTH'(e.ov));
                chk("out_data", out_data, e.od);
                chk("occ", WIDTH'(occ), WIDTH'(e.occ));
                chk("delay_q", WIDTH'(delay_q), WIDTH'(e.dly));
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'hdead);

        // Default delay, continuous stream.
        for (int i = 0; i < 24; i++) shift(1'b1, WIDTH'(i));

        // Delay 1 and clamping.
        cfg(1);
        shift(1'b1, 32'ha5);
        shift(1'b1, 32'h5a);
        idle(3);
        cfg(0);
        shift(1'b1, 32'h77);
        idle(2);
        cfg(MAX_DELAY + 5);
        idle(2);

        // Delay 4 with en toggling; in_* on stalled cycles must be ignored.
        cfg(4);
        for (int i = 0; i < 20; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, 1'b0, 1'b0, 0, (i < 6), WIDTH'(10 + i / 2));
            else step(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 32'hbad0 + WIDTH'(i));
        end

        // Delay 16, flush mid-stream drops in-flight words and the flush-cycle word.
        cfg(16);
        for (int i = 0; i < 3; i++) shift(1'b1, 32'h100 + WIDTH'(i));
        step(1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 32'h103);
        shift(1'b1, 32'h104);
        idle(20);

        // Sparse traffic at delay 3.
        cfg(3);
        shift(1'b1, 32'd7);
        shift(1'b0, 32'hffff);
        shift(1'b0, 32'heeee);
        shift(1'b1, 32'd9);
        idle(6);

        // flush + cfg_we together with a valid input; stall-time cfg_we.
        for (int i = 0; i < 4; i++) shift(1'b1, 32'h200 + WIDTH'(i));
        step(1'b0, 1'b1, 1'b1, 1'b1, 5, 1'b1, 32'h2ff);
        for (int i = 0; i < 8; i++) shift(1'b1, 32'h300 + WIDTH'(i));
        step(1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b1, 32'h3ff);
        for (int i = 0; i < 4; i++) shift(1'b1, 32'h400 + WIDTH'(i));

        // Reset mid-stream.
        step(1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b1, 32'h500);
        for (int i = 0; i < 12; i++) shift(1'b1, 32'h600 + WIDTH'(i));

        // Randomized traffic with small delays so outputs recur often.
        for (int i = 0; i < 3000; i++) begin
            int unsigned roll;
            int unsigned d;
            roll = $urandom_range(0, 999);
            d = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 12);
            step(roll < 3, $urandom_range(0, 3) != 0, roll >= 3 && roll < 20, roll >= 20 && roll < 30,
                 d, $urandom_range(0, 2) != 0, $urandom);
        end
        idle(MAX_DELAY + 2);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", WIDTH'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
